// File: rtl/taxi_pkg.sv
// ---------------------------------------------------------------------------
// taxi_pkg
// Shared definitions for the taxi meter fare path: the trip state encoding
// and the default tariff constants. The fare display/BCD stage imports the
// same tariff, so both sides agree on what a cent means.
// ---------------------------------------------------------------------------
package taxi_pkg;

    // Trip lifecycle as seen by the fare calculator.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HOLD  = 2'd3
    } trip_state_e;

    // Default tariff (cents / metres / minutes).
    localparam int unsigned DEF_BASE_FARE = 1000;
    localparam int unsigned DEF_BASE_DIST = 3000;
    localparam int unsigned DEF_UNIT_DIST = 1000;
    localparam int unsigned DEF_KM_RATE   = 200;
    localparam int unsigned DEF_WAIT_RATE = 50;
    localparam int unsigned DEF_FARE_W    = 20;

endpackage

// File: rtl/fare_sat_add.sv
// ---------------------------------------------------------------------------
// fare_sat_add
// Saturating unsigned adder for fare arithmetic. Clamps to all-ones instead
// of wrapping, so a long trip can never roll the meter back to a small fare.
//
// Ports:
//   a   [W-1:0]  input   current fare
//   b   [W-1:0]  input   charge to add (zero when no charge is due)
//   sum [W-1:0]  output  min(a + b, 2^W - 1)
// ---------------------------------------------------------------------------
module fare_sat_add
    import taxi_pkg::*;
#(
    parameter int unsigned W = DEF_FARE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W:0] wide;

    // The extra top bit is the carry out; any carry means the true sum does
    // not fit and the result pins at full scale.
    assign wide = {1'b0, a} + {1'b0, b};
    assign sum  = wide[W] ? {W{1'b1}} : wide[W-1:0];

endmodule

// File: rtl/taxi_fare_calc.sv
// ---------------------------------------------------------------------------
// taxi_fare_calc
// Integrates cumulative trip distance and low-speed time from the meter
// front end into a running fare in cents. The fare is built up one charge
// at a time from per-cycle deltas, so the settled value survives the
// upstream counters clearing once the trip is stopped.
//
// Ports:
//   clk          input            system clock
//   rst          input            synchronous, active-high reset
//   start        input            one-cycle pulse, begin a new trip
//   pause_state  input            level, meter paused (no billing)
//   stop_state   input            level, trip ended
//   distance     input  [31:0]    cumulative trip metres
//   low_time     input  [31:0]    cumulative low-speed minutes
//   fare         output [FARE_W]  current / settled fare in cents
//   fare_valid   output           one-cycle pulse on entering HOLD
//   trip_active  output           high while in RUN or PAUSE
// ---------------------------------------------------------------------------
module taxi_fare_calc
    import taxi_pkg::*;
#(
    parameter int unsigned BASE_FARE = DEF_BASE_FARE,
    parameter int unsigned BASE_DIST = DEF_BASE_DIST,
    parameter int unsigned UNIT_DIST = DEF_UNIT_DIST,
    parameter int unsigned KM_RATE   = DEF_KM_RATE,
    parameter int unsigned WAIT_RATE = DEF_WAIT_RATE,
    parameter int unsigned FARE_W    = DEF_FARE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause_state,
    input  logic              stop_state,
    input  logic [31:0]       distance,
    input  logic [31:0]       low_time,
    output logic [FARE_W-1:0] fare,
    output logic              fare_valid,
    output logic              trip_active
);

    localparam logic [31:0]       BASE_DIST_L = 32'(BASE_DIST);
    localparam logic [31:0]       UNIT_DIST_L = 32'(UNIT_DIST);
    localparam logic [FARE_W-1:0] BASE_FARE_L = FARE_W'(BASE_FARE);
    localparam logic [FARE_W-1:0] KM_RATE_L   = FARE_W'(KM_RATE);
    localparam logic [FARE_W-1:0] WAIT_RATE_L = FARE_W'(WAIT_RATE);

    trip_state_e       state_q, state_d;
    logic [FARE_W-1:0] fare_q, fare_d;
    logic              fare_valid_q, fare_valid_d;
    logic [31:0]       prev_dist_q, prev_dist_d;
    logic [31:0]       prev_low_q, prev_low_d;
    logic [31:0]       base_m_q, base_m_d;   // metres covered by the flag-fall
    logic [31:0]       seg_m_q, seg_m_d;     // unbilled metres beyond the base

    // Per-cycle charge computation (meaningful only in RUN).
    logic [31:0]       delta;
    logic [31:0]       room;
    logic [31:0]       overflow;
    logic [31:0]       base_fill;
    logic [32:0]       seg_sum;
    logic [31:0]       seg_cap;
    logic [31:0]       seg_next;
    logic              km_due;
    logic              wait_due;
    logic [FARE_W-1:0] km_add;
    logic [FARE_W-1:0] wait_add;
    logic [FARE_W-1:0] fare_km;
    logic [FARE_W-1:0] fare_both;

    // NOTE: every signal written in an always_comb gets a value before any
    // branch, otherwise a missed path would hold its old value and infer a latch.
    always_comb begin
        delta     = '0;
        overflow  = '0;
        base_fill = base_m_q;

        // Upstream counters only go backwards when they clear; treat that as
        // no movement rather than a huge unsigned delta.
        if (distance >= prev_dist_q) begin
            delta = distance - prev_dist_q;
        end

        // Fill the flag-fall allowance first; only the spill is billable.
        room = BASE_DIST_L - base_m_q;
        if (delta <= room) begin
            base_fill = base_m_q + delta;
        end else begin
            base_fill = BASE_DIST_L;
            overflow  = delta - room;
        end

        // Clamp rather than wrap if a bogus jump ever overflows 32 bits.
        seg_sum  = {1'b0, seg_m_q} + {1'b0, overflow};
        seg_cap  = seg_sum[32] ? '1 : seg_sum[31:0];

        // One unit per cycle; any surplus stays in seg_m for later cycles.
        km_due   = (seg_cap >= UNIT_DIST_L);
        seg_next = km_due ? (seg_cap - UNIT_DIST_L) : seg_cap;

        wait_due = (low_time > prev_low_q);
        km_add   = km_due   ? KM_RATE_L   : '0;
        wait_add = wait_due ? WAIT_RATE_L : '0;
    end

    // Two adders in series so a distance unit and a waiting minute landing on
    // the same cycle are both billed, each with its own saturation.
    fare_sat_add #(.W(FARE_W)) u_add_km (
        .a   (fare_q),
        .b   (km_add),
        .sum (fare_km)
    );

    fare_sat_add #(.W(FARE_W)) u_add_wait (
        .a   (fare_km),
        .b   (wait_add),
        .sum (fare_both)
    );

    // Next-state and register-update logic.
    always_comb begin
        state_d      = state_q;
        fare_d       = fare_q;
        fare_valid_d = 1'b0;
        prev_dist_d  = prev_dist_q;
        prev_low_d   = prev_low_q;
        base_m_d     = base_m_q;
        seg_m_d      = seg_m_q;

        case (state_q)
            IDLE, HOLD: begin
                // A start while the upstream still reports stop is stale.
                if (start && !stop_state) begin
                    state_d     = RUN;
                    fare_d      = BASE_FARE_L;
                    prev_dist_d = distance;
                    prev_low_d  = low_time;
                    base_m_d    = '0;
                    seg_m_d     = '0;
                end
            end

            RUN: begin
                if (stop_state) begin
                    // Stop wins over pause; this cycle's movement is not billed.
                    state_d      = HOLD;
                    fare_valid_d = 1'b1;
                end else begin
                    fare_d      = fare_both;
                    prev_dist_d = distance;
                    base_m_d    = base_fill;
                    seg_m_d     = seg_next;
                    // Waiting minutes are charged one per cycle, so prev_low
                    // walks up toward low_time instead of jumping to it.
                    if (wait_due) begin
                        prev_low_d = prev_low_q + 32'd1;
                    end else if (low_time < prev_low_q) begin
                        prev_low_d = low_time;
                    end
                    if (pause_state) begin
                        state_d = PAUSE;
                    end
                end
            end

            PAUSE: begin
                if (stop_state) begin
                    state_d      = HOLD;
                    fare_valid_d = 1'b1;
                end else begin
                    // Track the inputs so nothing moved during the pause is
                    // ever seen as a delta after resuming.
                    prev_dist_d = distance;
                    prev_low_d  = low_time;
                    if (!pause_state) begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fare_q       <= '0;
            fare_valid_q <= 1'b0;
            prev_dist_q  <= '0;
            prev_low_q   <= '0;
            base_m_q     <= '0;
            seg_m_q      <= '0;
        end else begin
            state_q      <= state_d;
            fare_q       <= fare_d;
            fare_valid_q <= fare_valid_d;
            prev_dist_q  <= prev_dist_d;
            prev_low_q   <= prev_low_d;
            base_m_q     <= base_m_d;
            seg_m_q      <= seg_m_d;
        end
    end

    assign fare        = fare_q;
    assign fare_valid  = fare_valid_q;
    assign trip_active = (state_q == RUN) || (state_q == PAUSE);

endmodule
